// File: rtl/eth_pkg.sv
// eth_pkg: Ethernet header constants, header struct, inserter FSM states and header-to-wire-byte helper
package eth_pkg;
  localparam int ETH_HDR_BYTES = 14;
  localparam int ETH_MIN_FRAME = 60;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
  } eth_hdr_t;
  typedef enum logic [2:0] {IDLE, HDR, DATA, FLUSH, PAD} eth_state_t;
  function automatic logic [ETH_HDR_BYTES*8-1:0] hdr_to_bytes(input eth_hdr_t h);
    logic [ETH_HDR_BYTES*8-1:0] r;
    for (int i = 0; i < ETH_HDR_BYTES; i++) r[i*8+:8] = h[(ETH_HDR_BYTES-1-i)*8+:8];
    return r;
  endfunction
endpackage

// File: rtl/eth_header_inserter.sv
// eth_header_inserter: prepends a 14-byte Ethernet header to a packed idx-format payload stream (ETH_PAD_EN pads frames to 60 bytes)
module eth_header_inserter
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  localparam int BYTES = DATA_WIDTH / 8,
  localparam int IW = $clog2(BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hdr_valid_in,
  output logic                  hdr_ready_out,
  input  logic [47:0]           dst_mac,
  input  logic [47:0]           src_mac,
  input  logic [15:0]           eth_type,
  input  logic [DATA_WIDTH-1:0] tdata_in,
  input  logic [IW-1:0]         idx_in,
  input  logic                  data_valid_in,
  input  logic                  last_flag_in,
  output logic                  data_ready_out,
  output logic [DATA_WIDTH-1:0] tdata_out,
  output logic [IW-1:0]         idx_out,
  output logic                  data_valid_out,
  output logic                  last_flag_out,
  input  logic                  tx_ready_in,
  output logic [15:0]           frame_len_out
);
  localparam int HF = ETH_HDR_BYTES / BYTES;
  localparam int OFF = ETH_HDR_BYTES % BYTES;
  localparam int IMW = (HF + 1) * DATA_WIDTH;
  eth_state_t state, state_n;
  logic [IMW-1:0] img, img_n;
  logic [OFF*8-1:0] carry, carry_n;
  logic [3:0] hcnt, hcnt_n;
  logic [IW-1:0] fn, fn_n, o_idx;
  logic [15:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] o_data, d_beat;
  logic load, go, o_last;
  int sum;
  function automatic logic [DATA_WIDTH-1:0] keep(input logic [DATA_WIDTH-1:0] d, input logic [IW-1:0] n);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < BYTES; i++) r[i*8+:8] = i < int'(n) ? d[i*8+:8] : 8'h00;
    return r;
  endfunction
  assign load = !data_valid_out || tx_ready_in;
  assign hdr_ready_out = !rst && state == IDLE;
  assign data_ready_out = !rst && state == DATA && load;
  assign img_n = IMW'(hdr_to_bytes({dst_mac, src_mac, eth_type}));
  assign d_beat = {tdata_in[(BYTES-OFF)*8-1:0], carry};
  assign sum = OFF + int'(idx_in);
`ifdef ETH_PAD_EN
  int rem;
  assign rem = ETH_MIN_FRAME - int'(cnt);
`endif
  always_comb begin
    state_n = state;
    carry_n = carry;
    hcnt_n = hcnt;
    fn_n = fn;
    o_data = '0;
    o_idx = '0;
    o_last = 1'b0;
    go = 1'b0;
    case (state)
      IDLE: if (hdr_valid_in) begin
        carry_n = img_n[HF*DATA_WIDTH +: OFF*8];
        go = HF > 0 && load;
        o_data = go ? img_n[DATA_WIDTH-1:0] : '0;
        o_idx = go ? IW'(BYTES) : '0;
        hcnt_n = go ? 4'd1 : 4'd0;
        state_n = HF == 0 ? DATA : (go && HF == 1) ? DATA : HDR;
      end
      HDR: if (load) begin
        go = 1'b1;
        o_data = img[hcnt*DATA_WIDTH +: DATA_WIDTH];
        o_idx = IW'(BYTES);
        hcnt_n = hcnt + 4'd1;
        state_n = int'(hcnt) == HF - 1 ? DATA : HDR;
      end
      DATA: if (data_valid_in && load) begin
        go = 1'b1;
        carry_n = tdata_in[DATA_WIDTH-1 -: OFF*8];
        o_last = last_flag_in && sum <= BYTES;
        o_idx = o_last ? IW'(sum) : IW'(BYTES);
        o_data = keep(d_beat, o_idx);
        fn_n = IW'(sum - BYTES);
        state_n = !last_flag_in ? DATA : o_last ? IDLE : FLUSH;
      end
      FLUSH: if (load) begin
        go = 1'b1;
        o_idx = fn;
        o_data = keep(DATA_WIDTH'(carry), fn);
        o_last = 1'b1;
        state_n = IDLE;
      end
`ifdef ETH_PAD_EN
      PAD: if (load) begin
        go = 1'b1;
        o_last = rem <= BYTES;
        o_idx = o_last ? IW'(rem) : IW'(BYTES);
        state_n = o_last ? IDLE : PAD;
      end
`endif
      default: state_n = IDLE;
    endcase
    cnt_n = (state == IDLE ? 16'd0 : cnt) + (go ? 16'(o_idx) : 16'd0);
`ifdef ETH_PAD_EN
    if (o_last && cnt_n < 16'(ETH_MIN_FRAME)) begin
      o_last = 1'b0;
      state_n = PAD;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      img <= '0;
      carry <= '0;
      hcnt <= '0;
      fn <= '0;
      cnt <= '0;
      tdata_out <= '0;
      idx_out <= '0;
      data_valid_out <= 1'b0;
      last_flag_out <= 1'b0;
      frame_len_out <= '0;
    end else begin
      state <= state_n;
      carry <= carry_n;
      hcnt <= hcnt_n;
      fn <= fn_n;
      cnt <= cnt_n;
      if (state == IDLE && hdr_valid_in) img <= img_n;
      if (load) begin
        data_valid_out <= go;
        tdata_out <= o_data;
        idx_out <= o_idx;
        last_flag_out <= o_last;
      end
      if (go && o_last) frame_len_out <= cnt_n;
    end
  end
endmodule
